// File: rtl/dm_dump_engine_if.sv
// dm_dump_engine_if: command, data-memory read port and output stream of the dump engine
interface dm_dump_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_cnt;
  logic              busy;
  logic              done;
  logic              dm_rd_en;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  modport master (
    input  start, base_addr, word_cnt, dm_rdata, out_ready,
    output busy, done, dm_rd_en, dm_addr, out_valid, out_data, out_last
  );
  modport slave (
    output start, base_addr, word_cnt, dm_rdata, out_ready,
    input  busy, done, dm_rd_en, dm_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dm_dump_engine.sv
// dm_dump_engine: streams a contiguous data-memory range over valid/ready.
// Define DM_DUMP_CHECKSUM_EN to append a modular-sum checksum word after the data.
module dm_dump_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  dm_dump_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WAIT, SEND} state_t;
  localparam logic [ADDR_W:0] ONE = 1;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last, done, hs, last_hs, more, go;
  assign go   = state == IDLE && bus.start;
  assign hs   = state == SEND && out_valid && bus.out_ready;
  assign more = rem > ONE;
`ifdef DM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
  // rem reaches zero once the last data word is accepted, so SEND with rem==0 is the checksum word
  assign last_hs = hs && rem == '0;
`else
  assign last_hs = hs && rem == ONE;
`endif
  assign bus.dm_rd_en  = state == RD || (hs && more);
  assign bus.dm_addr   = hs ? addr + ADDR_W'(1) : addr;
  assign bus.busy      = state != IDLE;
  assign bus.done      = done;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go && bus.word_cnt != '0 ? RD : IDLE;
      RD:      state_n = WAIT;
      WAIT:    state_n = SEND;
      SEND:    state_n = !hs ? SEND : more ? WAIT : last_hs ? IDLE : SEND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_hs || (go && bus.word_cnt == '0);
      if (go) begin
        addr <= bus.base_addr;
        rem  <= bus.word_cnt;
      end
      if (state == WAIT) begin
        out_data  <= bus.dm_rdata;
        out_valid <= 1'b1;
`ifdef DM_DUMP_CHECKSUM_EN
        out_last  <= 1'b0;
`else
        out_last  <= rem == ONE;
`endif
      end
      if (hs) begin
        addr      <= bus.dm_addr;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (rem != '0) rem <= rem - ONE;
`ifdef DM_DUMP_CHECKSUM_EN
        if (rem == ONE) begin
          out_valid <= 1'b1;
          out_data  <= acc;
          out_last  <= 1'b1;
        end
`endif
      end
    end
  end
`ifdef DM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)              acc <= '0;
    else if (go)          acc <= '0;
    else if (state == WAIT) acc <= acc + bus.dm_rdata;
`endif
endmodule
